// File: rtl/icache_sa_if.sv
// icache_sa_if: fetch-side and memory-side handshakes of icache_sa.
interface icache_sa_if #(
  parameter int ADDR_W = 32,
  parameter int INSTR_W = 32,
  parameter int LINE_W = 128
);
  logic req_valid;
  logic req_ready;
  logic [ADDR_W-1:0] req_addr;
  logic flush;
  logic resp_valid;
  logic [INSTR_W-1:0] resp_data;
  logic mem_req_valid;
  logic [ADDR_W-1:0] mem_req_addr;
  logic mem_req_ready;
  logic mem_resp_valid;
  logic [LINE_W-1:0] mem_resp_data;
  modport slave (
    input req_valid, req_addr, flush, mem_req_ready, mem_resp_valid, mem_resp_data,
    output req_ready, resp_valid, resp_data, mem_req_valid, mem_req_addr
  );
  modport master (
    output req_valid, req_addr, flush, mem_req_ready, mem_resp_valid, mem_resp_data,
    input req_ready, resp_valid, resp_data, mem_req_valid, mem_req_addr
  );
endinterface

// File: rtl/icache_sa.sv
// icache_sa: blocking set-associative read-only instruction cache with round-robin replacement and flush.
// Define ICACHE_STATS_EN to add saturating hit_count/miss_count outputs.
module icache_sa #(
  parameter int ADDR_W = 32,
  parameter int INSTR_W = 32,
  parameter int LINE_BYTES = 16,
  parameter int SETS = 16,
  parameter int WAYS = 2
) (
  input logic clk,
  input logic rst,
  icache_sa_if.slave bus
`ifdef ICACHE_STATS_EN
  ,
  output logic [31:0] hit_count,
  output logic [31:0] miss_count
`endif
);
  localparam int LINE_W = LINE_BYTES * 8;
  localparam int OFF = $clog2(LINE_BYTES);
  localparam int IDX = $clog2(SETS);
  localparam int TAG = ADDR_W - IDX - OFF;
  localparam int WB = $clog2(INSTR_W / 8);
  localparam int WORDS = LINE_W / INSTR_W;
  localparam int WI = WORDS > 1 ? $clog2(WORDS) : 1;
  localparam int WW = WAYS > 1 ? $clog2(WAYS) : 1;
  localparam logic [2:0] IDLE = 3'd0, LOOKUP = 3'd1, MISS_REQ = 3'd2, MISS_WAIT = 3'd3, REFILL = 3'd4;

  typedef logic [WORDS-1:0][INSTR_W-1:0] line_t;

  logic [2:0] state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  line_t line_q, line_d;
  logic flush_pend_q, flush_pend_d;
  logic [SETS-1:0][WAYS-1:0] valid_q, valid_d;
  logic [SETS-1:0][WW-1:0] rr_q, rr_d;
  logic [TAG-1:0] tag_q [SETS][WAYS];
  line_t data_q [SETS][WAYS];
  logic [IDX-1:0] idx;
  logic [TAG-1:0] tag;
  logic [WI-1:0] wi;
  logic hit, all_valid, do_flush, accept;
  logic [WW-1:0] hit_way, victim;

  assign idx = addr_q[OFF +: IDX];
  assign tag = addr_q[ADDR_W-1 -: TAG];
  assign wi = WORDS > 1 ? WI'(addr_q >> WB) : '0;

  // Scanning from the top leaves the lowest-index invalid way as victim.
  always_comb begin
    hit = 1'b0;
    hit_way = '0;
    victim = rr_q[idx];
    all_valid = &valid_q[idx];
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (valid_q[idx][w] && tag_q[idx][w] == tag) begin
        hit = 1'b1;
        hit_way = WW'(w);
      end
      if (!valid_q[idx][w]) victim = WW'(w);
    end
  end

  assign do_flush = state_q == IDLE && (bus.flush || flush_pend_q);
  assign bus.req_ready = rst && !bus.flush && (state_q == IDLE ? !flush_pend_q : state_q == LOOKUP && hit);
  assign accept = bus.req_valid && bus.req_ready;

  always_comb begin
    state_d = state_q;
    addr_d = accept ? bus.req_addr : addr_q;
    line_d = line_q;
    flush_pend_d = (flush_pend_q || bus.flush) && state_q != IDLE;
    valid_d = do_flush ? '0 : valid_q;
    rr_d = do_flush ? '0 : rr_q;
    case (state_q)
      IDLE: if (accept) state_d = LOOKUP;
      LOOKUP: state_d = !hit ? MISS_REQ : accept ? LOOKUP : IDLE;
      MISS_REQ: if (bus.mem_req_ready) state_d = MISS_WAIT;
      MISS_WAIT: if (bus.mem_resp_valid) begin
        state_d = REFILL;
        line_d = line_t'(bus.mem_resp_data);
      end
      REFILL: begin
        state_d = IDLE;
        valid_d[idx][victim] = 1'b1;
        if (all_valid && WAYS > 1) rr_d[idx] = rr_q[idx] + WW'(1);
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.resp_valid = (state_q == LOOKUP && hit) || state_q == REFILL;
  assign bus.resp_data = state_q == REFILL ? line_q[wi] :
                         (state_q == LOOKUP && hit) ? data_q[idx][hit_way][wi] : '0;
  assign bus.mem_req_valid = state_q == MISS_REQ;
  assign bus.mem_req_addr = {addr_q[ADDR_W-1:OFF], {OFF{1'b0}}};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      addr_q <= '0;
      line_q <= '0;
      flush_pend_q <= 1'b0;
      valid_q <= '0;
      rr_q <= '0;
    end else begin
      state_q <= state_d;
      addr_q <= addr_d;
      line_q <= line_d;
      flush_pend_q <= flush_pend_d;
      valid_q <= valid_d;
      rr_q <= rr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (state_q == REFILL) begin
      tag_q[idx][victim] <= tag;
      data_q[idx][victim] <= line_q;
    end
  end

`ifdef ICACHE_STATS_EN
  logic [31:0] hit_cnt_q, hit_cnt_d, miss_cnt_q, miss_cnt_d;

  always_comb begin
    hit_cnt_d = do_flush ? '0 : hit_cnt_q + 32'(state_q == LOOKUP && hit && hit_cnt_q != '1);
    miss_cnt_d = do_flush ? '0 : miss_cnt_q + 32'(state_q == LOOKUP && !hit && miss_cnt_q != '1);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hit_cnt_q <= '0;
      miss_cnt_q <= '0;
    end else begin
      hit_cnt_q <= hit_cnt_d;
      miss_cnt_q <= miss_cnt_d;
    end
  end

  assign hit_count = hit_cnt_q;
  assign miss_count = miss_cnt_q;
`endif
endmodule

// File: tb/tb_icache_sa.sv
// tb_icache_sa: directed scenarios for icache_sa with a response scoreboard.
module tb_icache_sa;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int errors = 0;
  int checks = 0;
  logic [31:0] exp_q[$];

  icache_sa_if #(.ADDR_W(32), .INSTR_W(32), .LINE_W(128)) bus();
`ifdef ICACHE_STATS_EN
  logic [31:0] hit_count, miss_count;
`endif

  icache_sa dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
`ifdef ICACHE_STATS_EN
    ,
    .hit_count(hit_count),
    .miss_count(miss_count)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Memory image: line 0x100 is the cold-miss line, all others are address-derived.
  function automatic logic [127:0] line_of(input logic [31:0] b);
    logic [31:0] w [4];
    for (int i = 0; i < 4; i++) w[i] = 32'hC0DE0000 | (b + 32'(4 * i));
    return b == 32'h100 ? {32'h44, 32'h33, 32'h22, 32'h11} : {w[3], w[2], w[1], w[0]};
  endfunction

  function automatic logic [31:0] exp_word(input logic [31:0] a);
    logic [127:0] l;
    l = line_of(a & ~32'hF);
    return l[int'(a[3:2]) * 32 +: 32];
  endfunction

  always @(negedge clk) begin
    if (rst && bus.resp_valid) begin
      chk("resp_expected", exp_q.size() != 0, 1);
      if (exp_q.size() != 0) chk("resp_data", bus.resp_data, exp_q.pop_front());
    end
  end

  task automatic reset_dut();
    rst = 1'b0;
    exp_q.delete();
    @(negedge clk);
    chk("rst_req_ready", bus.req_ready, 0);
    chk("rst_resp_valid", bus.resp_valid, 0);
    chk("rst_mreq_valid", bus.mem_req_valid, 0);
    chk("rst_mreq_addr", bus.mem_req_addr, 0);
    @(posedge clk); #1;
    rst = 1'b1;
  endtask

  task automatic drive_req(input logic [31:0] a);
    bus.req_valid = 1'b1;
    bus.req_addr = a;
    exp_q.push_back(exp_word(a));
    @(negedge clk);
    chk("req_ready", bus.req_ready, 1);
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
  endtask

  task automatic miss(input logic [31:0] a, input int lat);
    drive_req(a);
    @(negedge clk);
    chk("miss_no_hit", bus.resp_valid, 0);
    chk("lookup_no_mreq", bus.mem_req_valid, 0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("mreq_valid", bus.mem_req_valid, 1);
    chk("mreq_addr", bus.mem_req_addr, a & ~32'hF);
    @(posedge clk); #1;
    bus.mem_req_ready = 1'b1;
    @(negedge clk);
    chk("mreq_hold", bus.mem_req_valid, 1);
    chk("mreq_addr_stable", bus.mem_req_addr, a & ~32'hF);
    @(posedge clk); #1;
    bus.mem_req_ready = 1'b0;
    repeat (lat) begin
      @(negedge clk);
      chk("wait_no_mreq", bus.mem_req_valid, 0);
      chk("wait_no_resp", bus.resp_valid, 0);
      @(posedge clk); #1;
    end
    bus.mem_resp_valid = 1'b1;
    bus.mem_resp_data = line_of(a & ~32'hF);
    @(posedge clk); #1;
    bus.mem_resp_valid = 1'b0;
    bus.mem_resp_data = '0;
    @(negedge clk);
    chk("refill_resp", bus.resp_valid, 1);
    @(posedge clk); #1;
  endtask

  task automatic hits(input logic [31:0] as [4], input int n);
    for (int i = 0; i < n; i++) begin
      bus.req_valid = 1'b1;
      bus.req_addr = as[i];
      exp_q.push_back(exp_word(as[i]));
      @(negedge clk);
      chk("hit_ready", bus.req_ready, 1);
      chk("hit_no_mreq", bus.mem_req_valid, 0);
      if (i > 0) chk("hit_b2b_resp", bus.resp_valid, 1);
      @(posedge clk); #1;
    end
    bus.req_valid = 1'b0;
    @(negedge clk);
    chk("hit_last_resp", bus.resp_valid, 1);
    chk("hit_no_mreq", bus.mem_req_valid, 0);
    @(posedge clk); #1;
  endtask

  initial begin
    bus.req_valid = 1'b0;
    bus.req_addr = '0;
    bus.flush = 1'b0;
    bus.mem_req_ready = 1'b0;
    bus.mem_resp_valid = 1'b0;
    bus.mem_resp_data = '0;
    reset_dut();
    // Cold miss then back-to-back hits on the same line.
    miss(32'h100, 2);
    hits('{32'h104, 32'h108, 32'h10C, 32'h0}, 3);
`ifdef ICACHE_STATS_EN
    @(negedge clk);
    chk("stats_hits", hit_count, 3);
    chk("stats_misses", miss_count, 1);
    @(posedge clk); #1;
`endif
    // Three lines into set 0: the third evicts way 0 (0x000).
    reset_dut();
    miss(32'h000, 1);
    miss(32'h100, 0);
    miss(32'h200, 1);
    hits('{32'h104, 32'h0, 32'h0, 32'h0}, 1);
    miss(32'h000, 1);
    hits('{32'h208, 32'h0, 32'h0, 32'h0}, 1);
    // Flush in IDLE beats a simultaneous request.
    bus.flush = 1'b1;
    bus.req_valid = 1'b1;
    bus.req_addr = 32'h204;
    @(negedge clk);
    chk("flush_blocks_req", bus.req_ready, 0);
    @(posedge clk); #1;
    bus.flush = 1'b0;
    bus.req_valid = 1'b0;
    @(negedge clk);
    chk("flush_req_dropped", bus.resp_valid, 0);
`ifdef ICACHE_STATS_EN
    chk("stats_flush_hits", hit_count, 0);
    chk("stats_flush_misses", miss_count, 0);
`endif
    @(posedge clk); #1;
    miss(32'h104, 0);
    // Flush raised during a hit LOOKUP is held and applied in the next IDLE.
    bus.req_valid = 1'b1;
    bus.req_addr = 32'h104;
    exp_q.push_back(exp_word(32'h104));
    @(negedge clk);
    chk("req_ready", bus.req_ready, 1);
    @(posedge clk); #1;
    bus.flush = 1'b1;
    bus.req_addr = 32'h108;
    @(negedge clk);
    chk("lookup_hit_resp", bus.resp_valid, 1);
    chk("ready_low_on_flush", bus.req_ready, 0);
    @(posedge clk); #1;
    bus.flush = 1'b0;
    @(negedge clk);
    chk("pending_flush_blocks", bus.req_ready, 0);
    @(posedge clk); #1;
    miss(32'h108, 1);
    // Reset in MISS_REQ drops mem_req_valid immediately.
    drive_req(32'h300);
    @(posedge clk); #1;
    @(negedge clk);
    chk("mreq_before_rst", bus.mem_req_valid, 1);
    #1 rst = 1'b0;
    #1;
    chk("rst_drop_mreq", bus.mem_req_valid, 0);
    chk("rst_ready_low", bus.req_ready, 0);
    exp_q.delete();
    @(posedge clk); #1;
    rst = 1'b1;
    // Reset in MISS_WAIT; the late memory response must be ignored.
    drive_req(32'h100);
    @(posedge clk); #1;
    bus.mem_req_ready = 1'b1;
    @(posedge clk); #1;
    bus.mem_req_ready = 1'b0;
    @(negedge clk);
    chk("wait_state_no_mreq", bus.mem_req_valid, 0);
    #1 rst = 1'b0;
    #1;
    chk("rst_wait_ready_low", bus.req_ready, 0);
    chk("rst_wait_no_resp", bus.resp_valid, 0);
    exp_q.delete();
    @(posedge clk); #1;
    rst = 1'b1;
    bus.mem_resp_valid = 1'b1;
    bus.mem_resp_data = line_of(32'h100);
    bus.mem_req_ready = 1'b1;
    @(negedge clk);
    chk("stale_resp_ignored", bus.resp_valid, 0);
    chk("idle_ready_after_rst", bus.req_ready, 1);
    @(posedge clk); #1;
    bus.mem_resp_valid = 1'b0;
    bus.mem_resp_data = '0;
    bus.mem_req_ready = 1'b0;
    @(negedge clk);
    chk("stale_no_state_change", bus.resp_valid, 0);
    @(posedge clk); #1;
    miss(32'h100, 2);
    chk("scoreboard_drained", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
